// File: rtl/membus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : membus_if
// Description : Memory-bus handshake bundle. A request (valid/ready with
//               addr, wen, wdata, wmask) is followed later by a single
//               response beat (rvalid with rdata).
// Revision    : 1.0 - initial release
// ============================================================================
interface membus_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_W-1:0]     addr;
  logic                  wen;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wmask;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  // Side that issues requests and consumes responses
  modport master (output valid, addr, wen, wdata, wmask,
                  input  ready, rvalid, rdata);
  // Side that accepts requests and produces responses
  modport slave  (input  valid, addr, wen, wdata, wmask,
                  output ready, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/membus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : membus_arbiter
// Description : Merges an instruction-fetch and a load/store requester onto
//               one memory bus with at most one request in flight. Grants are
//               round-robin under contention, held through stalls, and the
//               response is routed back to the requester that owns it.
//               Request and response paths are purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module membus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic     clk,
  input  logic     rst,
  membus_if.slave  i_membus,
  membus_if.slave  d_membus,
  membus_if.master membus,
  output logic     spurious_rvalid
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;
  localparam logic [MASK_W-1:0] MASK_ZERO = '0;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_e;

  logic outstanding;
  req_e owner;
  logic locked;
  req_e lock_owner;
  req_e last_grant;

  logic window;
  req_e grant;
  logic grant_valid;
  logic issue;
  logic accept;
  logic resp;

  // Grant selection: lock holds a stalled grant, otherwise round-robin
  always_comb begin
    window = rst && (!outstanding || membus.rvalid);
    grant  = last_grant;
    if (locked) begin
      grant = lock_owner;
    end else if (i_membus.valid && d_membus.valid) begin
      grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (d_membus.valid) begin
      grant = REQ_D;
    end else begin
      grant = REQ_I;
    end
    grant_valid = (grant == REQ_D) ? d_membus.valid : i_membus.valid;
    issue       = window && grant_valid;
    accept      = issue && membus.ready;
    resp        = rst && outstanding && membus.rvalid;
  end

  // Request mux toward the bus; all fields zero unless a grant is issued
  always_comb begin
    membus.valid   = 1'b0;
    membus.addr    = ADDR_ZERO;
    membus.wen     = 1'b0;
    membus.wdata   = DATA_ZERO;
    membus.wmask   = MASK_ZERO;
    i_membus.ready = 1'b0;
    d_membus.ready = 1'b0;
    if (issue) begin
      membus.valid = 1'b1;
      if (grant == REQ_D) begin
        membus.addr    = d_membus.addr;
        membus.wen     = d_membus.wen;
        membus.wdata   = d_membus.wdata;
        membus.wmask   = d_membus.wmask;
        d_membus.ready = membus.ready;
      end else begin
        membus.addr    = i_membus.addr;
        membus.wen     = i_membus.wen;
        membus.wdata   = i_membus.wdata;
        membus.wmask   = i_membus.wmask;
        i_membus.ready = membus.ready;
      end
    end
  end

  // Response routing to the owner; a response with nothing in flight is dropped
  always_comb begin
    i_membus.rvalid = resp && (owner == REQ_I);
    d_membus.rvalid = resp && (owner == REQ_D);
    i_membus.rdata  = (resp && (owner == REQ_I)) ? membus.rdata : DATA_ZERO;
    d_membus.rdata  = (resp && (owner == REQ_D)) ? membus.rdata : DATA_ZERO;
    spurious_rvalid = rst && !outstanding && membus.rvalid;
  end

  // Bookkeeping: in-flight owner, stall lock and round-robin history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= 1'b0;
      owner       <= REQ_I;
      locked      <= 1'b0;
      lock_owner  <= REQ_I;
      last_grant  <= REQ_I;
    end else if (accept) begin
      // A response in the same cycle retires the old request; the new one replaces it
      outstanding <= 1'b1;
      owner       <= grant;
      last_grant  <= grant;
      locked      <= 1'b0;
    end else begin
      if (issue) begin
        locked     <= 1'b1;
        lock_owner <= grant;
      end else if (window && locked) begin
        // Lock owner withdrew its request; reopen arbitration
        locked <= 1'b0;
      end
      if (resp) begin
        outstanding <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_membus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_membus_arbiter
// Description : Directed scenarios followed by randomized traffic, checked
//               every cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_membus_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spurious;

  membus_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();
  membus_if #(.ADDR_W(AW), .DATA_W(DW)) db ();
  membus_if #(.ADDR_W(AW), .DATA_W(DW)) mb ();

  membus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_membus        (ib),
    .d_membus        (db),
    .membus          (mb),
    .spurious_rvalid (spurious)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: 0 = I requester, 1 = D requester, -1 = nobody
  int pend[$];          // owners of accepted requests still awaiting a response
  int stalled = -1;     // requester whose issued request is waiting for ready
  int last    = 0;      // requester most recently accepted
  int e_grant = -1;
  bit e_accept = 1'b0;
  bit e_resp   = 1'b0;
  bit hold_i   = 1'b0;
  bit hold_d   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (stalled >= 0) return stalled;
    if (ib.valid && db.valid) return (last == 0) ? 1 : 0;
    if (ib.valid) return 0;
    if (db.valid) return 1;
    return -1;
  endfunction

  // Compare every DUT output against the model mid-cycle
  task automatic settle();
    bit            open;
    int            g;
    int            ro;
    logic [63:0]   x_addr, x_wdata;
    logic [7:0]    x_wmask;
    logic          x_wen;
    @(negedge clk);
    if (!rst) begin
      pend.delete();
      stalled = -1;
      last    = 0;
    end
    open    = rst && ((pend.size() == 0) || mb.rvalid);
    g       = open ? model_grant() : -1;
    e_grant = g;
    e_accept = (g >= 0) && mb.ready;
    e_resp  = rst && (pend.size() != 0) && mb.rvalid;
    ro      = e_resp ? pend[0] : -1;
    x_addr  = (g == 0) ? ib.addr  : (g == 1) ? db.addr  : 64'h0;
    x_wdata = (g == 0) ? ib.wdata : (g == 1) ? db.wdata : 64'h0;
    x_wmask = (g == 0) ? ib.wmask : (g == 1) ? db.wmask : 8'h0;
    x_wen   = (g == 0) ? ib.wen   : (g == 1) ? db.wen   : 1'b0;
    chk("m_valid",  mb.valid, (g >= 0));
    chk("m_addr",   mb.addr,  x_addr);
    chk("m_wen",    mb.wen,   x_wen);
    chk("m_wdata",  mb.wdata, x_wdata);
    chk("m_wmask",  mb.wmask, x_wmask);
    chk("i_ready",  ib.ready, (g == 0) && mb.ready);
    chk("d_ready",  db.ready, (g == 1) && mb.ready);
    chk("i_rvalid", ib.rvalid, (ro == 0));
    chk("d_rvalid", db.rvalid, (ro == 1));
    chk("i_rdata",  ib.rdata, (ro == 0) ? mb.rdata : 64'h0);
    chk("d_rdata",  db.rdata, (ro == 1) ? mb.rdata : 64'h0);
    chk("spurious", spurious, rst && (pend.size() == 0) && mb.rvalid);
  endtask

  // Advance the model on the clock edge, then let inputs change
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (e_resp) void'(pend.pop_front());
      if (e_accept) begin
        pend.push_back(e_grant);
        last    = e_grant;
        stalled = -1;
      end else if (e_grant >= 0) begin
        stalled = e_grant;
      end
      hold_i = ib.valid && !(e_accept && e_grant == 0);
      hold_d = db.valid && !(e_accept && e_grant == 1);
    end else begin
      hold_i = 1'b0;
      hold_d = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    ib.valid = 1'b0; ib.addr = '0; ib.wen = 1'b0; ib.wdata = '0; ib.wmask = '0;
    db.valid = 1'b0; db.addr = '0; db.wen = 1'b0; db.wdata = '0; db.wmask = '0;
    mb.ready = 1'b0; mb.rvalid = 1'b0; mb.rdata = '0;
  endtask

  task automatic rand_inputs();
    if (!hold_i) begin
      ib.valid = ($urandom_range(0, 99) < 50);
      ib.addr  = {$urandom, $urandom};
      ib.wen   = 1'($urandom_range(0, 1));
      ib.wdata = {$urandom, $urandom};
      ib.wmask = 8'($urandom);
    end
    if (!hold_d) begin
      db.valid = ($urandom_range(0, 99) < 50);
      db.addr  = {$urandom, $urandom};
      db.wen   = 1'($urandom_range(0, 1));
      db.wdata = {$urandom, $urandom};
      db.wmask = 8'($urandom);
    end
    mb.ready  = ($urandom_range(0, 99) < 60);
    mb.rvalid = (pend.size() != 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
    mb.rdata  = {$urandom, $urandom};
    rst       = ($urandom_range(0, 99) != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    // Reset with every input active: all outputs must stay quiet
    idle();
    rst = 1'b0;
    ib.valid = 1'b1; db.valid = 1'b1; mb.ready = 1'b1; mb.rvalid = 1'b1; mb.rdata = 64'hDEAD;
    settle();
    chk("rst_m_valid", mb.valid, 0);
    chk("rst_spur",    spurious, 0);
    chk("rst_i_ready", ib.ready, 0);
    tick();
    idle();
    rst = 1'b1;

    // Contention after reset: D first, I back-to-back, D again
    ib.valid = 1'b1; ib.addr = 64'h2000; db.valid = 1'b1; db.addr = 64'h3000; mb.ready = 1'b1;
    settle();
    chk("c1_d_ready", db.ready, 1);
    chk("c1_i_ready", ib.ready, 0);
    chk("c1_addr",    mb.addr,  64'h3000);
    tick();
    db.valid = 1'b0; mb.rvalid = 1'b1; mb.rdata = 64'h11;
    settle();
    chk("c2_d_rvalid", db.rvalid, 1);
    chk("c2_d_rdata",  db.rdata,  64'h11);
    chk("c2_i_ready",  ib.ready,  1);
    chk("c2_addr",     mb.addr,   64'h2000);
    tick();
    ib.addr = 64'h2008; db.valid = 1'b1; db.addr = 64'h3008; mb.rdata = 64'h22;
    settle();
    chk("c3_i_rvalid", ib.rvalid, 1);
    chk("c3_d_ready",  db.ready,  1);
    chk("c3_i_ready",  ib.ready,  0);
    tick();
    ib.valid = 1'b0; db.valid = 1'b0; mb.rdata = 64'h33;
    settle();
    chk("c4_d_rvalid", db.rvalid, 1);
    tick();
    idle();

    // Stall lock: D holds the grant through three stalled cycles
    db.valid = 1'b1; db.addr = 64'h4000;
    settle();
    chk("s1_valid", mb.valid, 1);
    chk("s1_addr",  mb.addr,  64'h4000);
    chk("s1_d_ready", db.ready, 0);
    tick();
    ib.valid = 1'b1; ib.addr = 64'h5000;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("s23_addr",    mb.addr,  64'h4000);
      chk("s23_i_ready", ib.ready, 0);
      tick();
    end
    mb.ready = 1'b1;
    settle();
    chk("s4_d_ready", db.ready, 1);
    chk("s4_i_ready", ib.ready, 0);
    tick();
    ib.valid = 1'b0; db.valid = 1'b0; mb.ready = 1'b0; mb.rvalid = 1'b1; mb.rdata = 64'h44;
    settle();
    chk("s5_d_rvalid", db.rvalid, 1);
    chk("s5_i_rvalid", ib.rvalid, 0);
    tick();
    idle();

    // Single I read
    ib.valid = 1'b1; ib.addr = 64'h1000; mb.ready = 1'b1;
    settle();
    chk("r_addr",    mb.addr,  64'h1000);
    chk("r_i_ready", ib.ready, 1);
    tick();
    ib.valid = 1'b0; mb.rvalid = 1'b1; mb.rdata = 64'hAA;
    settle();
    chk("r_i_rvalid", ib.rvalid, 1);
    chk("r_i_rdata",  ib.rdata,  64'hAA);
    chk("r_d_rvalid", db.rvalid, 0);
    tick();
    idle();

    // Spurious response with nothing in flight
    mb.rvalid = 1'b1; mb.rdata = 64'h55;
    settle();
    chk("sp_flag",     spurious,  1);
    chk("sp_i_rvalid", ib.rvalid, 0);
    chk("sp_d_rvalid", db.rvalid, 0);
    tick();
    mb.rvalid = 1'b0;
    settle();
    chk("sp_clear", spurious, 0);
    tick();

    // Reset while a D write is in flight
    db.valid = 1'b1; db.addr = 64'h6000; db.wen = 1'b1; db.wmask = 8'hFF; db.wdata = 64'h77; mb.ready = 1'b1;
    settle();
    chk("w_wen",   mb.wen,   1);
    chk("w_wmask", mb.wmask, 8'hFF);
    tick();
    db.valid = 1'b0; db.wen = 1'b0; mb.ready = 1'b0; rst = 1'b0;
    settle();
    chk("wr_m_valid", mb.valid, 0);
    tick();
    mb.rvalid = 1'b1; mb.rdata = 64'h99;
    settle();
    chk("wr_spur_in_rst", spurious,  0);
    chk("wr_d_rvalid0",   db.rvalid, 0);
    tick();
    rst = 1'b1;
    settle();
    chk("wr_spur",     spurious,  1);
    chk("wr_d_rvalid", db.rvalid, 0);
    tick();
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
